// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the fetch stage: state encoding, fault codes and
// the architectural constants the fetch logic and its users agree on.
package pc_fetch_unit_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'b00,
        ST_RUN    = 2'b01,
        ST_HALTED = 2'b10
    } fetch_state_e;

    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_RANGE    = 2'b10;

    localparam logic [31:0] NOP_WORD        = 32'h0000_0013;
    localparam logic [31:0] EBREAK_WORD_DEF = 32'h0010_0073;

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC and fault selection for the fetch stage.
// A PC outside the ROM outranks any redirect; a redirect must be word aligned.
module fetch_next_pc
    import pc_fetch_unit_pkg::*;
#(
    parameter int IMEM_DEPTH = 64
) (
    input  logic [XLEN-1:0] pc_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_target_i,
    output logic [XLEN-1:0] next_pc_o,
    output logic [1:0]      fault_o
);

    localparam logic [XLEN-1:0] PC_LIMIT = XLEN'(IMEM_DEPTH * 4);

    // Classify the current fetch and pick the sequential or redirected PC.
    always_comb begin
        fault_o   = FAULT_NONE;
        next_pc_o = pc_i + 32'd4;
        if (pc_i >= PC_LIMIT) begin
            fault_o = FAULT_RANGE;
        end else if (redirect_valid_i && (redirect_target_i[1:0] != 2'b00)) begin
            fault_o = FAULT_MISALIGN;
        end else begin
            fault_o = FAULT_NONE;
        end
        if (redirect_valid_i) begin
            next_pc_o = redirect_target_i;
        end else begin
            next_pc_o = pc_i + 32'd4;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage: owns the PC, drives the instruction ROM address and registers
// the returned word with its PC for the decoder. Halts on ebreak or fault.
// Optional build macro FETCH_PERF_COUNTER_EN adds the fetch_count output.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          IMEM_DEPTH  = 64,
    parameter logic [31:0] EBREAK_WORD = EBREAK_WORD_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_instr,
    output logic [XLEN-1:0] instr_out,
    output logic [XLEN-1:0] pc_out,
    output logic            instr_valid,
    output logic            halted,
    output logic [1:0]      fault
`ifdef FETCH_PERF_COUNTER_EN
    ,
    output logic [31:0]     fetch_count
`endif
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pc_out_q, pc_out_d;
    logic            valid_q, valid_d;
    logic            halted_q, halted_d;
    logic [1:0]      fault_q, fault_d;
    logic [XLEN-1:0] next_pc_s;
    logic [1:0]      fault_code_s;
`ifdef FETCH_PERF_COUNTER_EN
    logic [31:0]     count_q, count_d;
`endif

    fetch_next_pc #(
        .IMEM_DEPTH (IMEM_DEPTH)
    ) u_next_pc (
        .pc_i              (pc_q),
        .redirect_valid_i  (redirect_valid),
        .redirect_target_i (redirect_target),
        .next_pc_o         (next_pc_s),
        .fault_o           (fault_code_s)
    );

    // Next-state logic: fault > redirect > stall > normal fetch while running.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        pc_out_d = pc_out_q;
        valid_d  = valid_q;
        halted_d = halted_q;
        fault_d  = fault_q;
`ifdef FETCH_PERF_COUNTER_EN
        count_d  = count_q;
`endif
        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (fault_code_s != FAULT_NONE) begin
                    state_d  = ST_HALTED;
                    halted_d = 1'b1;
                    fault_d  = fault_code_s;
                    valid_d  = 1'b0;
                end else if (redirect_valid) begin
                    // Word already on the bus is wrong-path: squash it.
                    pc_d    = next_pc_s;
                    valid_d = 1'b0;
                end else if (stall) begin
                    valid_d = valid_q;
                end else begin
                    instr_d  = imem_instr;
                    pc_out_d = pc_q;
                    valid_d  = 1'b1;
                    pc_d     = next_pc_s;
`ifdef FETCH_PERF_COUNTER_EN
                    count_d  = count_q + 32'd1;
`endif
                    if (imem_instr == EBREAK_WORD) begin
                        state_d  = ST_HALTED;
                        halted_d = 1'b1;
                    end else begin
                        state_d  = ST_RUN;
                    end
                end
            end
            ST_HALTED: begin
                valid_d  = 1'b0;
                halted_d = 1'b1;
            end
            default: begin
                state_d  = ST_HALTED;
                halted_d = 1'b1;
                valid_d  = 1'b0;
            end
        endcase
    end

    // State and pipeline registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_BOOT;
            pc_q     <= RESET_PC;
            instr_q  <= NOP_WORD;
            pc_out_q <= 32'h0000_0000;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            fault_q  <= FAULT_NONE;
`ifdef FETCH_PERF_COUNTER_EN
            count_q  <= 32'h0000_0000;
`endif
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
            fault_q  <= fault_d;
`ifdef FETCH_PERF_COUNTER_EN
            count_q  <= count_d;
`endif
        end
    end

    assign imem_addr   = pc_q;
    assign instr_out   = instr_q;
    assign pc_out      = pc_out_q;
    assign instr_valid = valid_q;
    assign halted      = halted_q;
    assign fault       = fault_q;
`ifdef FETCH_PERF_COUNTER_EN
    assign fetch_count = count_q;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios followed by
// randomized stall/redirect/reset traffic, compared against a behavioural model.
module tb_pc_fetch_unit;

    localparam logic [31:0] EBREAK = 32'h0010_0073;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        instr_valid;
    logic        halted;
    logic [1:0]  fault;
`ifdef FETCH_PERF_COUNTER_EN
    logic [31:0] fetch_count;
`endif

    logic [31:0] rom [0:63];

    int n_cmp = 0;
    int n_err = 0;

    // model state: mode 0 = boot bubble, 1 = fetching, 2 = stopped
    int          m_mode;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pc_out;
    logic        m_valid;
    logic        m_halted;
    logic [1:0]  m_fault;
    logic [31:0] m_count;

    pc_fetch_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_addr       (imem_addr),
        .imem_instr      (imem_instr),
        .instr_out       (instr_out),
        .pc_out          (pc_out),
        .instr_valid     (instr_valid),
        .halted          (halted),
        .fault           (fault)
`ifdef FETCH_PERF_COUNTER_EN
        ,
        .fetch_count     (fetch_count)
`endif
    );

    always #5 clk = ~clk;

    // Combinational instruction ROM; reads outside it return zero.
    always_comb begin
        imem_instr = (imem_addr < 32'h100) ? rom[imem_addr[7:2]] : 32'h0;
    end

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return (a < 32'h100) ? rom[a / 4] : 32'h0;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Apply the fetch rules for one rising edge given the current inputs.
    task automatic model_edge();
        logic [31:0] w;
        if (!rst_n) begin
            m_mode = 0; m_pc = 32'h0; m_instr = 32'h0000_0013; m_pc_out = 32'h0;
            m_valid = 1'b0; m_halted = 1'b0; m_fault = 2'b00; m_count = 32'h0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (m_pc >= 32'd256) begin
                m_mode = 2; m_halted = 1'b1; m_fault = 2'b10; m_valid = 1'b0;
            end else if (redirect_valid && (redirect_target % 4 != 0)) begin
                m_mode = 2; m_halted = 1'b1; m_fault = 2'b01; m_valid = 1'b0;
            end else if (redirect_valid) begin
                m_pc = redirect_target; m_valid = 1'b0;
            end else if (!stall) begin
                w = rom_word(m_pc);
                m_instr = w; m_pc_out = m_pc; m_valid = 1'b1;
                m_pc = m_pc + 32'd4; m_count = m_count + 32'd1;
                if (w == EBREAK) begin
                    m_mode = 2; m_halted = 1'b1;
                end
            end
        end else begin
            m_valid = 1'b0;
        end
    endtask

    task automatic compare_all();
        check_eq("imem_addr", imem_addr, m_pc);
        check_eq("instr_out", instr_out, m_instr);
        check_eq("pc_out", pc_out, m_pc_out);
        check_eq("instr_valid", {31'b0, instr_valid}, {31'b0, m_valid});
        check_eq("halted", {31'b0, halted}, {31'b0, m_halted});
        check_eq("fault", {30'b0, fault}, {30'b0, m_fault});
`ifdef FETCH_PERF_COUNTER_EN
        check_eq("fetch_count", fetch_count, m_count);
`endif
    endtask

    // Drive inputs, take one edge, then compare away from the edge.
    task automatic cycle(input logic rn, input logic st, input logic rv, input logic [31:0] rt);
        rst_n = rn; stall = st; redirect_valid = rv; redirect_target = rt;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic fill_rom(input int ebreak_pct);
        for (int i = 0; i < 64; i++) begin
            rom[i] = $urandom;
            if (rom[i] == EBREAK) rom[i] = 32'h0000_0013;
            if (int'($urandom_range(0, 99)) < ebreak_pct) rom[i] = EBREAK;
        end
    endtask

    initial begin
        logic [31:0] tgt;
        int r;
        int guard;

        // ---- directed: reset, first fetches, stall, redirect, misalign ----
        fill_rom(0);
        rom[0] = 32'h0020_81B3;
        rom[1] = 32'h4020_81B3;
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        check_eq("rst_valid", {31'b0, instr_valid}, 32'd0);
        check_eq("rst_instr", instr_out, 32'h0000_0013);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check_eq("boot_valid", {31'b0, instr_valid}, 32'd0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check_eq("first_instr", instr_out, 32'h0020_81B3);
        check_eq("first_pc", pc_out, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check_eq("second_instr", instr_out, 32'h4020_81B3);
        check_eq("second_pc", pc_out, 32'h4);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0);
        check_eq("stall_addr", imem_addr, 32'h8);
        check_eq("stall_pc", pc_out, 32'h4);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check_eq("resume_pc", pc_out, 32'h8);
        cycle(1'b1, 1'b1, 1'b1, 32'h20);
        check_eq("redir_valid", {31'b0, instr_valid}, 32'd0);
        check_eq("redir_addr", imem_addr, 32'h20);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check_eq("redir_pc", pc_out, 32'h20);
        cycle(1'b1, 1'b0, 1'b1, 32'h22);
        check_eq("mis_halted", {31'b0, halted}, 32'd1);
        check_eq("mis_fault", {30'b0, fault}, 32'd1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1, 32'h40);
        check_eq("halt_addr", imem_addr, 32'h24);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        check_eq("rerst_addr", imem_addr, 32'h0);
        check_eq("rerst_fault", {30'b0, fault}, 32'd0);

        // ---- directed: run off the end of the ROM ----
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        guard = 0;
        while (!m_halted && guard < 100) begin
            cycle(1'b1, 1'b0, 1'b0, 32'h0);
            guard++;
        end
        check_eq("range_fault", {30'b0, fault}, 32'd2);
        check_eq("range_last_pc", pc_out, 32'hFC);
        check_eq("range_halted", {31'b0, halted}, 32'd1);

        // ---- directed: ebreak at word 2 ----
        rom[2] = EBREAK;
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check_eq("ebreak_instr", instr_out, EBREAK);
        check_eq("ebreak_pc", pc_out, 32'h8);
        check_eq("ebreak_valid", {31'b0, instr_valid}, 32'd1);
        check_eq("ebreak_halted", {31'b0, halted}, 32'd1);
`ifdef FETCH_PERF_COUNTER_EN
        check_eq("ebreak_count", fetch_count, 32'd3);
`endif
        cycle(1'b1, 1'b0, 1'b1, 32'h10);
        check_eq("ebreak_after_valid", {31'b0, instr_valid}, 32'd0);
        check_eq("ebreak_frozen_addr", imem_addr, 32'hC);

        // ---- randomized episodes ----
        for (int ep = 0; ep < 20; ep++) begin
            fill_rom(2);
            cycle(1'b0, 1'b0, 1'b0, 32'h0);
            for (int c = 0; c < 150; c++) begin
                r = int'($urandom_range(0, 9));
                if (r == 0)      tgt = ($urandom_range(0, 70) * 4) + $urandom_range(1, 3);
                else if (r == 1) tgt = 32'h100 - ($urandom_range(0, 3) * 4);
                else             tgt = $urandom_range(0, 63) * 4;
                cycle(($urandom_range(0, 199) != 0),
                      ($urandom_range(0, 3) == 0),
                      ($urandom_range(0, 9) == 0),
                      tgt);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
